serial_mag_comparator: RTL and testbench
========================================

# serial_mag_comparator

Bit-serial, MSB-first magnitude comparator for two N-bit unsigned operands. It is the receiving end of a serial operand link: it accepts one bit of `a` and one bit of `b` per qualified cycle and, after N bits, raises a one-cycle `done` strobe. At that point it publishes the same six relational flags as the lab's parallel comparator (eq, neq, lt, lte, gt, gte). It sits downstream of a serialiser or shift-out stage and replaces the wide parallel compare where operands arrive serially.

## Interface
- `N`, default 8: operand width in bits; legal range is N ≥ 1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a new comparison; sampled only in IDLE and DONE.
- `bit_valid`, input, 1: qualifies `a_bit`/`b_bit`; sampled only in SHIFT.
- `a_bit`, input, 1: current bit of operand a, MSB first.
- `b_bit`, input, 1: current bit of operand b, MSB first.
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: one-cycle strobe in the DONE state.
- `eq`, `neq`, `lt`, `lte`, `gt`, `gte`, output, 1 each: registered result flags, held until the next comparison completes.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `start`=1 → SHIFT. Clears the bit counter, `dec` (decided) and `gt_r`/`lt_r`.
  - SHIFT: on each cycle with `bit_valid`=1:
    - If `dec`=0 and `a_bit`≠`b_bit`, set `dec`=1, `gt_r`=`a_bit`, `lt_r`=`b_bit`.
    - Once `dec`=1, later bits do not change `gt_r`/`lt_r`.
    - Increment the counter on every qualified cycle.
  - SHIFT → DONE: on the edge that samples the N-th qualified bit. The result flags update on that same edge, including that bit's contribution.
  - SHIFT with `bit_valid`=0: stall. Counter and state hold indefinitely; there is no timeout.
  - DONE: lasts exactly one cycle. `start`=1 → SHIFT, re-clearing the counter, `dec`, `gt_r` and `lt_r`. Otherwise → IDLE.
- Flag definitions, with gt_f and lt_f the final decision values:
  - `gt`=gt_f, `lt`=lt_f
  - `eq`=~gt_f & ~lt_f, `neq`=gt_f | lt_f
  - `gte`=~lt_f, `lte`=~gt_f
- Flag invariants on every published result:
  - exactly one of `eq`/`lt`/`gt` is 1
  - `neq`=~`eq`
  - `lte`=`lt`|`eq`
  - `gte`=`gt`|`eq`
- `start` in SHIFT is ignored; an in-flight comparison is never aborted by `start`.
- `bit_valid` in IDLE or DONE is ignored; those bits are discarded.
- Bit counter width is $clog2(N+1). It saturates at N and must not wrap. For N=1 the first qualified bit completes the compare.
- Between completions, the flags hold the last published result. They do not change during SHIFT.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, all six flags=0, counter=0, `dec`=0.
  - All-zero flags is the only legal state in which the invariants do not hold; it means "no result yet".
- Reset asserted mid-SHIFT or in DONE: on the next edge, all of the above reset values apply; the partial comparison is discarded.
- Cycle sequence:
  - `start` sampled at edge t0 → `busy`=1 from t0.
  - The first bit can be sampled at edge t0+1.
- Latency with no stalls: `done`=1 in the cycle after the edge at t0+N, i.e. N+1 edges after `start`. Each `bit_valid`=0 cycle in SHIFT adds one cycle.
- `busy` and `done` are never both high.
- `done` is never high for two consecutive cycles.
- Back-to-back operation: with `start` held high during DONE, the next comparison begins with no idle gap. Throughput is one compare per N+1 cycles.

## Test plan
- Equal operands: N=8, a=b=8'hA5, bits streamed MSB first with no stalls.
  - Required: `done` exactly 9 edges after `start`.
  - Flags: eq=1, neq=0, lt=0, lte=1, gt=0, gte=1.
- MSB decides, later bits ignored: a=8'h80, b=8'h7F.
  - Required: gt=1, gte=1, neq=1, all other flags 0.
  - Then a=8'h01, b=8'h02 → lt=1, lte=1, neq=1, all other flags 0.
- Stalls: a=8'h3C, b=8'h3D, with `bit_valid` deasserted for 3 cycles after bit 4.
  - Required: `done` at 12 edges after `start`; lt=1.
  - `busy`=1 throughout SHIFT; flags unchanged until completion.
- Ignored controls: pulse `start` mid-SHIFT and drive `bit_valid`=1 while IDLE.
  - Required: no restart, no extra bits counted, result is correct for the original operands.
- Reset mid-operation: assert `reset` after 5 bits of a=8'hFF, b=8'h00.
  - Required: next cycle `busy`=0, `done`=0, all flags 0.
  - A fresh compare of a=8'h10, b=8'h10 then yields eq=1.
- Back-to-back: hold `start` high in DONE and run 10 random operand pairs.
  - Required: each result matches a parallel reference compare.
  - Flag invariants hold on every `done`.
  - No idle cycle between runs.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// Bit-serial, MSB-first unsigned magnitude comparator. Consumes one qualified bit pair per
// cycle and publishes eq/neq/lt/lte/gt/gte with a one-cycle done strobe after N bits.
module serial_mag_comparator #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       busy,
    output logic       done,
    output logic       eq,
    output logic       neq,
    output logic       lt,
    output logic       lte,
    output logic       gt,
    output logic       gte,
    output logic [1:0] state_dbg
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Handshake: a_bit/b_bit are consumed on a rising edge only when bit_valid is high
    // and the block is busy; there is no back-pressure, so bits offered at other times are dropped.

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_q, dec_d;
    logic          gt_r_q, gt_r_d;
    logic          lt_r_q, lt_r_d;
    logic          eq_q, neq_q, lt_q, lte_q, gt_q, gte_q;
    logic          eq_d, neq_d, lt_d, lte_d, gt_d, gte_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        gt_r_d  = gt_r_q;
        lt_r_d  = lt_r_q;
        eq_d    = eq_q;
        neq_d   = neq_q;
        lt_d    = lt_q;
        lte_d   = lte_q;
        gt_d    = gt_q;
        gte_d   = gte_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    gt_r_d  = 1'b0;
                    lt_r_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    // The first differing bit (MSB first) fixes the outcome for good.
                    if (!dec_q && (a_bit != b_bit)) begin
                        dec_d  = 1'b1;
                        gt_r_d = a_bit;
                        lt_r_d = b_bit;
                    end
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        gt_d    = gt_r_d;
                        lt_d    = lt_r_d;
                        eq_d    = ~gt_r_d & ~lt_r_d;
                        neq_d   = gt_r_d | lt_r_d;
                        gte_d   = ~lt_r_d;
                        lte_d   = ~gt_r_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            gt_r_q  <= 1'b0;
            lt_r_q  <= 1'b0;
            eq_q    <= 1'b0;
            neq_q   <= 1'b0;
            lt_q    <= 1'b0;
            lte_q   <= 1'b0;
            gt_q    <= 1'b0;
            gte_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            gt_r_q  <= gt_r_d;
            lt_r_q  <= lt_r_d;
            eq_q    <= eq_d;
            neq_q   <= neq_d;
            lt_q    <= lt_d;
            lte_q   <= lte_d;
            gt_q    <= gt_d;
            gte_q   <= gte_d;
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;
    assign eq        = eq_q;
    assign neq       = neq_q;
    assign lt        = lt_q;
    assign lte       = lte_q;
    assign gt        = gt_q;
    assign gte       = gte_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: table of operand pairs with hand-computed flags,
// plus stall, ignored-control, reset and back-to-back sequences.
module tb_serial_mag_comparator;

    localparam int N = 8;
    // Flag vectors packed as {eq, neq, lt, lte, gt, gte}.
    localparam logic [5:0] F_EQ = 6'b100101;
    localparam logic [5:0] F_LT = 6'b011100;
    localparam logic [5:0] F_GT = 6'b010011;

    logic       clk = 1'b0;
    logic       reset, start, bit_valid, a_bit, b_bit;
    logic       busy, done, eq, neq, lt, lte, gt, gte;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[9];

    serial_mag_comparator #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
        .eq(eq), .neq(neq), .lt(lt), .lte(lte), .gt(gt), .gte(gte),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] flags();
        return {eq, neq, lt, lte, gt, gte};
    endfunction

    function automatic logic [5:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
        if (a == b) return F_EQ;
        else if (a < b) return F_LT;
        else return F_GT;
    endfunction

    function automatic logic invariants_ok();
        return ((eq + lt + gt) == 1) && (neq == ~eq) && (lte == (lt | eq)) && (gte == (gt | eq));
    endfunction

    // One compare. Inputs are driven and outputs sampled just after the falling edge.
    // chained: start was already raised during the previous DONE cycle.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic [5:0] exp,
                           input bit chained, input bit chain_next,
                           input int stall_at, input int stall_len, input int pulse_at);
        int         edges;
        logic [5:0] held;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
        end
        held = flags();
        @(negedge clk);
        edges = 1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_low_at_shift_entry", done, 0);
        for (int i = N - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            if ((N - 1 - i) == pulse_at) start = 1'b1;
            @(negedge clk);
            edges++;
            start     = 1'b0;
            bit_valid = 1'b0;
            if (i > 0) begin
                check("busy_mid_shift", busy, 1);
                check("flags_held_mid_shift", flags(), held);
            end
            if ((N - i) == stall_at) begin
                repeat (stall_len) begin
                    a_bit = 1'($urandom_range(0, 1));
                    b_bit = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    edges++;
                    check("busy_in_stall", busy, 1);
                    check("flags_held_in_stall", flags(), held);
                end
            end
        end
        while (!done && edges < N + 1 + stall_len + 20) begin
            @(negedge clk);
            edges++;
        end
        check("done_seen", done, 1);
        check("done_latency", edges, N + 1 + stall_len);
        check("busy_low_with_done", busy, 0);
        check("result_flags", flags(), exp);
        check("flag_invariants", invariants_ok(), 1);
        if (chain_next) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_single_cycle", done, 0);
            check("idle_after_done", state_dbg, 0);
            check("flags_hold_after_done", flags(), exp);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [5:0] held;

        vecs[0] = '{8'hA5, 8'hA5, F_EQ};
        vecs[1] = '{8'h80, 8'h7F, F_GT};
        vecs[2] = '{8'h01, 8'h02, F_LT};
        vecs[3] = '{8'h00, 8'h00, F_EQ};
        vecs[4] = '{8'hFF, 8'hFF, F_EQ};
        vecs[5] = '{8'hFF, 8'hFE, F_GT};
        vecs[6] = '{8'h00, 8'h01, F_LT};
        vecs[7] = '{8'h7F, 8'h80, F_LT};
        vecs[8] = '{8'h55, 8'h54, F_GT};

        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_flags", flags(), 6'b000000);
        check("reset_state", state_dbg, 0);
        reset = 1'b0;

        foreach (vecs[k]) run_cmp(vecs[k].a, vecs[k].b, vecs[k].exp, 1'b0, 1'b0, 0, 0, -1);

        // Three-cycle stall after bit 4: done at 12 edges after start.
        run_cmp(8'h3C, 8'h3D, F_LT, 1'b0, 1'b0, 4, 3, -1);

        // bit_valid while idle must be discarded.
        held = flags();
        repeat (3) begin
            @(negedge clk);
            bit_valid = 1'b1;
            a_bit = 1'($urandom_range(0, 1));
            b_bit = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("idle_bits_no_busy", busy, 0);
        check("idle_bits_flags_held", flags(), held);
        // start pulsed alongside bit 2 must not restart the compare.
        run_cmp(8'h12, 8'h13, F_LT, 1'b0, 1'b0, 0, 0, 2);

        // Reset after 5 bits of FF vs 00.
        ra = 8'hFF; rb = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            bit_valid = 1'b1; a_bit = ra[i]; b_bit = rb[i];
            @(negedge clk);
        end
        check("pre_reset_busy", busy, 1);
        reset = 1'b1; bit_valid = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_flags", flags(), 6'b000000);
        check("midreset_state", state_dbg, 0);
        reset = 1'b0;
        run_cmp(8'h10, 8'h10, F_EQ, 1'b0, 1'b0, 0, 0, -1);

        // Back-to-back with start held during DONE.
        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k == 3) ? ra : 8'($urandom_range(0, 255));
            run_cmp(ra, rb, ref_flags(ra, rb), k > 0, k < 9, 0, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
